dmem_unit: RTL and testbench
============================

# dmem_unit

Parametrised, byte-addressable, little-endian data memory for the CPU load/store path, with a valid/ready request port and a single-cycle response pulse. It generalises the 4 KB data memory in three ways: configurable depth, hardware splitting of misaligned accesses into two beats, and a post-reset zero-initialisation sequencer in place of an asynchronous array clear. It sits between the execute stage's load/store unit and the writeback mux.

## Interface
- ADDR_BITS, 12: byte-address bits used; capacity is 2^ADDR_BITS bytes; minimum 3; addr[31:ADDR_BITS] ignored, so addresses wrap.
- MISALIGN_SPLIT, 1: 1 = misaligned half/word split into two beats; 0 = misaligned access returns an error.
- INIT_ZERO, 1: 1 = zero all words after reset release; 0 = contents undefined after reset.
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  asynchronous reset, active low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; the request is accepted at an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 invalid.
- req_signext  in  1  sign-extend byte/half loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle response pulse; the consumer cannot stall it.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  the request was invalid; no memory change.

## Operation
- Storage: 4 byte lanes, each 2^(ADDR_BITS-2) entries. Word index = addr[ADDR_BITS-1:2]. Lane = addr[1:0].
- FSM states: INIT, IDLE, BEAT2.
  - Reset enters INIT if INIT_ZERO=1, otherwise IDLE.
  - INIT writes zero to one word per cycle, counter 0..2^(ADDR_BITS-2)-1, then goes to IDLE. req_ready=0 throughout.
  - IDLE: req_ready=1. The value of req_ready never depends on req_valid.
- Aligned access: byte at any address, half with addr[0]=0, word with addr[1:0]=0.
  - Byte enables apply at the accept edge.
  - A store writes at the accept edge. A load reads synchronously at the accept edge.
- Misaligned access with MISALIGN_SPLIT=1 is one that crosses a word boundary, or a half at an odd address within a word that still fits.
  - Accesses that fit inside one word complete in a single beat.
  - Accesses that cross a word complete in beat 1 (word i, upper lanes) at the accept edge, then BEAT2 (word i+1 mod depth, lower lanes) at the next edge.
  - The request fields are registered at accept.
- Error: req_size=11, or a word-crossing access with MISALIGN_SPLIT=0.
  - No write.
  - rsp_err=1, rsp_rdata=0.
- Load formatting: bytes are assembled little-endian and then extended to 32 bits.
  - Zero extension by default; sign extension from bit 7 or bit 15 when req_signext=1.
  - req_signext is ignored for word loads and stores.
- Stores return rsp_valid with rsp_rdata=0 and rsp_err=0.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM in INIT or IDLE; init counter at 0.
- Single-beat request accepted at edge N: rsp_valid high for cycle N+1 only.
- Split request accepted at edge N: req_ready=0 during cycle N+1; rsp_valid high for cycle N+2.
- Throughput: one accept per cycle for single-beat traffic; a split access costs one bubble.
- Read-after-write: a store accepted at N followed by a load to the same bytes accepted at N+1 returns the new data. There is no hazard logic; writes complete at the accept edge.
- Reset mid-BEAT2:
  - The first-beat bytes stay written, the second beat is dropped, and no response is issued.
  - The FSM returns to INIT or IDLE per INIT_ZERO.
- Reset mid-INIT: the counter restarts at 0.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state enum;
  - a function mapping (size, addr[1:0]) to a byte-enable mask for beat 1, a mask for beat 2, and a crosses flag.
- Sub-module dmem_bank: one byte lane, synchronous write with enable, synchronous read, no reset. It is instantiated 4 times.
- Lane rotation, beat merge and extension logic live in dmem_unit.

## Test plan
- Reset, INIT_ZERO=1, ADDR_BITS=12: req_ready low for exactly 1024 cycles after release, then high. Load word 0xFFC → 0x00000000.
- Store word 0xDEADBEEF at 0x100. Byte load signext at 0x103 → 0xFFFFFFDE. Half load unsigned at 0x102 → 0x0000DEAD.
- MISALIGN_SPLIT=1: store word 0x11223344 at 0xFFE (wraps).
  - req_ready low for cycle N+1; rsp_valid at N+2.
  - Load word 0x000 → 0x00001122. Load half 0xFFE → 0x00003344.
- MISALIGN_SPLIT=0:
  - Load half 0x103 → rsp_err=1, rsp_rdata=0 at N+1.
  - Size 11 store → rsp_err=1, memory unchanged.
  - Half at 0x101 → valid, no error.
- Back-to-back: store word 0xCAFEF00D at 0x200 (edge N), load word 0x200 (edge N+1) → 0xCAFEF00D at N+2. req_ready stays 1.
- INIT_ZERO=0: split store at 0x7FF with reset asserted during BEAT2 → no rsp_valid. Byte 0x7FF holds the new value; 0x800 is unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and lane-mask helper for the byte-addressable data memory.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_BEAT2
   } state_t;

   typedef struct packed {
      logic [3:0] be1;
      logic [3:0] be2;
      logic       crosses;
   } lane_map_t;

   // Lanes touched in word i (be1) and word i+1 (be2); an invalid size touches nothing.
   function automatic lane_map_t lane_map(input logic [1:0] size, input logic [1:0] lo);
      logic [7:0] m;
      lane_map_t  r;
      case (size)
         SZ_BYTE: m = 8'b0000_0001;
         SZ_HALF: m = 8'b0000_0011;
         SZ_WORD: m = 8'b0000_1111;
         default: m = 8'b0000_0000;
      endcase
      m         = m << lo;
      r.be1     = m[3:0];
      r.be2     = m[7:4];
      r.crosses = |m[7:4];
      return r;
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: synchronous write with enable, synchronous read.
module dmem_bank #(
   parameter int IDX_BITS = 10
) (
   input  logic                clk,
   input  logic                we,
   input  logic [IDX_BITS-1:0] idx,
   input  logic [7:0]          wdata,
   output logic [7:0]          rdata
);

   logic [7:0] mem [2**IDX_BITS];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dmem_unit.sv
// Byte-addressable little-endian data memory with valid/ready requests, misaligned
// access splitting over two beats and a post-reset zero-fill sequencer.
module dmem_unit
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS      = 12,
   parameter bit MISALIGN_SPLIT = 1'b1,
   parameter bit INIT_ZERO      = 1'b1
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signext,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int            IW       = ADDR_BITS - 2;
   localparam logic [IW-1:0] IDX_LAST = '1;

   state_t        state, state_nxt;
   logic [IW-1:0] cnt;

   lane_map_t     map_p0;
   logic [1:0]    lo_p0;
   logic          err_p0, acc_p0, split_p0;
   logic [31:0]   wrot_p0;

   logic          vld_p1, ld_p1, err_p1, split_p1, sext_p1;
   logic [1:0]    lo_p1, size_p1;
   logic [IW-1:0] idx_p1;
   logic [3:0]    be2_p1;
   logic [31:0]   wrot_p1, hold_p1;

   logic [3:0]    bank_we;
   logic [IW-1:0] bank_idx;
   logic [31:0]   bank_wd, rd_w;
   logic [31:0]   lo_word, raw;
   logic          unused_hi;

   function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] n);
      logic [63:0] dd;
      dd = {d, d} << (8 * n);
      return dd[63:32];
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                          input logic sext);
      case (size)
         SZ_BYTE: return {{24{sext & d[7]}}, d[7:0]};
         SZ_HALF: return {{16{sext & d[15]}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   // Stage p0: request decode at the accept edge
   assign unused_hi = ^req_addr[31:ADDR_BITS];
   assign lo_p0     = req_addr[1:0];
   assign map_p0    = lane_map(req_size, lo_p0);
   assign err_p0    = (req_size == 2'b11) || (map_p0.crosses && !MISALIGN_SPLIT);
   assign split_p0  = map_p0.crosses && !err_p0;
   assign req_ready = arst_n && (state == ST_IDLE);
   assign acc_p0    = req_valid && req_ready;
   assign wrot_p0   = rotl_bytes(req_wdata, lo_p0);

   always_comb begin
      state_nxt = state;
      bank_we   = 4'b0000;
      bank_idx  = req_addr[ADDR_BITS-1:2];
      bank_wd   = wrot_p0;
      case (state)
         ST_INIT: begin
            bank_we  = 4'b1111;
            bank_idx = cnt;
            bank_wd  = '0;
            if (cnt == IDX_LAST) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (acc_p0 && req_we && !err_p0) bank_we = map_p0.be1;
            if (acc_p0 && split_p0) state_nxt = ST_BEAT2;
         end
         ST_BEAT2: begin
            bank_idx  = idx_p1 + IW'(1);
            bank_wd   = wrot_p1;
            if (!ld_p1) bank_we = be2_p1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state  <= INIT_ZERO ? ST_INIT : ST_IDLE;
         cnt    <= '0;
         vld_p1 <= 1'b0;
      end else begin
         state  <= state_nxt;
         if (state == ST_INIT) cnt <= cnt + IW'(1);
         vld_p1 <= (acc_p0 && !split_p0) || (state == ST_BEAT2);
      end
   end

   // Stage p1: request fields held for the second beat and the response
   always_ff @(posedge clk) begin
      if (acc_p0) begin
         ld_p1    <= !req_we;
         err_p1   <= err_p0;
         split_p1 <= split_p0;
         sext_p1  <= req_signext;
         lo_p1    <= lo_p0;
         size_p1  <= req_size;
         idx_p1   <= req_addr[ADDR_BITS-1:2];
         be2_p1   <= map_p0.be2;
         wrot_p1  <= wrot_p0;
      end
      // The first-beat word is still on the bank outputs during the BEAT2 cycle.
      if (state == ST_BEAT2) hold_p1 <= rd_w;
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      dmem_bank #(.IDX_BITS(IW)) u_bank (
         .clk   (clk),
         .we    (bank_we[g]),
         .idx   (bank_idx),
         .wdata (bank_wd[8*g +: 8]),
         .rdata (rd_w[8*g +: 8])
      );
   end

   // Stage p2: merge beats, realign and extend
   always_comb begin
      lo_word   = split_p1 ? hold_p1 : rd_w;
      raw       = 32'({rd_w, lo_word} >> (8 * lo_p1));
      rsp_rdata = '0;
      if (vld_p1 && ld_p1 && !err_p1) rsp_rdata = extend(raw, size_p1, sext_p1);
   end

   assign rsp_valid = vld_p1;
   assign rsp_err   = vld_p1 && err_p1;

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: three instances (split+zero-init, no-split, split without init).
module tb_dmem_unit;

   logic            clk = 1'b0;
   logic [2:0]      arst_n, req_valid, req_ready, req_we, req_signext, rsp_valid, rsp_err;
   logic [2:0][1:0] req_size;
   logic [2:0][31:0] req_addr, req_wdata, rsp_rdata;

   int compares   = 0;
   int mismatches = 0;

   logic [7:0] mem_m [4096];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_unit #(.ADDR_BITS(12), .MISALIGN_SPLIT(g != 1), .INIT_ZERO(g == 0)) u_dut (
         .clk         (clk),
         .arst_n      (arst_n[g]),
         .req_valid   (req_valid[g]),
         .req_ready   (req_ready[g]),
         .req_we      (req_we[g]),
         .req_size    (req_size[g]),
         .req_signext (req_signext[g]),
         .req_addr    (req_addr[g]),
         .req_wdata   (req_wdata[g]),
         .rsp_valid   (rsp_valid[g]),
         .rsp_rdata   (rsp_rdata[g]),
         .rsp_err     (rsp_err[g])
      );
   end

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                              input bit sext);
      int n;
      logic [31:0] v;
      n = nbytes(size);
      v = '0;
      for (int k = 0; k < n; k++) v = v | (32'(mem_m[(addr + k) % 4096]) << (8 * k));
      if (sext && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sext && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   // Drives one request on instance d and waits (bounded) for its response.
   task automatic xact(input int d, input bit we, input logic [1:0] size, input bit sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output logic rdy1);
      int guard;
      guard = 0;
      while (req_ready[d] !== 1'b1 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) begin
         $display("FAIL ready_timeout dut%0d got ready=%b required 1", d, req_ready[d]);
         $fatal(1, "request port never became ready");
      end
      req_valid[d]   = 1'b1;
      req_we[d]      = we;
      req_size[d]    = size;
      req_signext[d] = sext;
      req_addr[d]    = addr;
      req_wdata[d]   = wdata;
      @(posedge clk);
      @(negedge clk);
      rdy1         = req_ready[d];
      req_valid[d] = 1'b0;
      lat          = 1;
      while (rsp_valid[d] !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      rdata = rsp_rdata[d];
      err   = rsp_err[d];
   endtask

   task automatic test_reset();
      int n;
      for (int d = 0; d < 3; d++) begin
         compares++;
         if ({req_ready[d], rsp_valid[d], rsp_err[d]} !== 3'b000 || rsp_rdata[d] !== 32'h0) begin
            mismatches++;
            $display("FAIL reset_values dut%0d got rdy=%b vld=%b err=%b rdata=%h required all 0",
                     d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
         end
      end
      arst_n = 3'b111;
      n = 0;
      #1;
      while (req_ready[0] !== 1'b1 && n < 3000) begin
         n++;
         @(negedge clk);
         #1;
      end
      compares++;
      if (n != 1024) begin
         mismatches++;
         $display("FAIL init_ready_low got %0d cycles required 1024", n);
      end
      compares++;
      if (req_ready[1] !== 1'b1 || req_ready[2] !== 1'b1) begin
         mismatches++;
         $display("FAIL noinit_ready got %b%b required 11", req_ready[1], req_ready[2]);
      end
   endtask

   task automatic test_basic();
      logic [31:0] r; logic e; int lat; logic rdy;
      xact(0, 0, 2'd2, 0, 32'hFFC, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'h0 || e !== 1'b0) begin
         mismatches++; $display("FAIL init_zero_load got %h err=%b required 00000000 err=0", r, e);
      end
      xact(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, r, e, lat, rdy);
      compares++;
      if (r !== 32'h0 || e !== 1'b0 || lat != 1) begin
         mismatches++; $display("FAIL store_rsp got %h err=%b lat=%0d required 0 0 1", r, e, lat);
      end
      xact(0, 0, 2'd0, 1, 32'h103, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'hFFFFFFDE) begin
         mismatches++; $display("FAIL byte_sext got %h required FFFFFFDE", r);
      end
      xact(0, 0, 2'd1, 0, 32'h102, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'h0000DEAD) begin
         mismatches++; $display("FAIL half_zext got %h required 0000DEAD", r);
      end
      xact(0, 0, 2'd1, 1, 32'h101, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'hFFFFADBE || lat != 1) begin
         mismatches++; $display("FAIL half_odd_inword got %h lat=%0d required FFFFADBE lat=1", r, lat);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] r; logic e; int lat; logic rdy;
      xact(0, 1, 2'd2, 0, 32'hFFE, 32'h11223344, r, e, lat, rdy);
      compares++;
      if (rdy !== 1'b0 || lat != 2 || e !== 1'b0) begin
         mismatches++;
         $display("FAIL split_timing got rdy1=%b lat=%0d err=%b required 0 2 0", rdy, lat, e);
      end
      xact(0, 0, 2'd2, 0, 32'h000, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'h00001122) begin
         mismatches++; $display("FAIL wrap_word0 got %h required 00001122", r);
      end
      xact(0, 0, 2'd1, 0, 32'hFFE, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'h00003344) begin
         mismatches++; $display("FAIL half_ffe got %h required 00003344", r);
      end
      xact(0, 0, 2'd2, 0, 32'hFFE, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'h11223344 || lat != 2) begin
         mismatches++; $display("FAIL split_load got %h lat=%0d required 11223344 lat=2", r, lat);
      end
   endtask

   task automatic test_nosplit();
      logic [31:0] r; logic e; int lat; logic rdy;
      xact(1, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, r, e, lat, rdy);
      xact(1, 0, 2'd1, 0, 32'h103, 0, r, e, lat, rdy);
      compares++;
      if (e !== 1'b1 || r !== 32'h0 || lat != 1) begin
         mismatches++; $display("FAIL nosplit_err got err=%b %h lat=%0d required 1 0 1", e, r, lat);
      end
      xact(1, 1, 2'd3, 0, 32'h100, 32'h0, r, e, lat, rdy);
      compares++;
      if (e !== 1'b1 || r !== 32'h0) begin
         mismatches++; $display("FAIL size11_err got err=%b %h required 1 0", e, r);
      end
      xact(1, 1, 2'd2, 0, 32'h102, 32'h0, r, e, lat, rdy);
      xact(1, 0, 2'd2, 0, 32'h100, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'hDEADBEEF || e !== 1'b0) begin
         mismatches++; $display("FAIL err_no_write got %h err=%b required DEADBEEF 0", r, e);
      end
      xact(1, 0, 2'd1, 0, 32'h101, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'h0000ADBE || e !== 1'b0) begin
         mismatches++; $display("FAIL nosplit_half101 got %h err=%b required 0000ADBE 0", r, e);
      end
   endtask

   task automatic test_back_to_back();
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd2; req_signext[0] = 1'b0;
      req_addr[0] = 32'h200; req_wdata[0] = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      compares++;
      if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
         mismatches++;
         $display("FAIL b2b_store got vld=%b err=%b rdy=%b required 1 0 1",
                  rsp_valid[0], rsp_err[0], req_ready[0]);
      end
      req_we[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      compares++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hCAFEF00D || req_ready[0] !== 1'b1) begin
         mismatches++;
         $display("FAIL b2b_load got vld=%b %h rdy=%b required 1 CAFEF00D 1",
                  rsp_valid[0], rsp_rdata[0], req_ready[0]);
      end
      req_valid[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [31:0] r, addr, wd, exp; logic e, rdy; int lat, n, explat;
      logic [1:0] sz; bit we, sx, experr;
      for (int a = 0; a < 4096; a++) mem_m[a] = 8'h00;
      for (int i = 0; i < 150; i++) begin
         addr = (32'h300 + 32'($urandom_range(0, 31))) | ($urandom & 32'hFFFF_F000);
         sz   = 2'($urandom_range(0, 3));
         we   = bit'($urandom_range(0, 1));
         sx   = bit'($urandom_range(0, 1));
         wd   = $urandom;
         experr = (sz == 2'd3);
         n      = nbytes(sz);
         explat = (!experr && (addr % 4) + n > 4) ? 2 : 1;
         exp    = (experr || we) ? 32'h0 : model_load(addr, sz, sx);
         xact(0, we, sz, sx, addr, wd, r, e, lat, rdy);
         if (we && !experr)
            for (int k = 0; k < n; k++) mem_m[(addr + k) % 4096] = wd[8*k +: 8];
         compares++;
         if (r !== exp || e !== experr || lat != explat) begin
            mismatches++;
            $display("FAIL rand%0d a=%h sz=%0d we=%0d got %h err=%b lat=%0d required %h %b %0d",
                     i, addr, sz, we, r, e, lat, exp, experr, explat);
         end
      end
   endtask

   task automatic test_reset_beat2();
      logic [31:0] r; logic e; int lat; logic rdy; bit seen;
      xact(2, 1, 2'd0, 0, 32'h800, 32'h55, r, e, lat, rdy);
      xact(2, 1, 2'd0, 0, 32'h7FF, 32'h11, r, e, lat, rdy);
      req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 2'd2;
      req_addr[2] = 32'h7FF; req_wdata[2] = 32'hA1B2C3D4;
      @(posedge clk);
      #1;
      arst_n[2] = 1'b0;
      req_valid[2] = 1'b0;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rsp_valid[2] !== 1'b0) seen = 1;
      end
      compares++;
      if (seen || req_ready[2] !== 1'b0) begin
         mismatches++;
         $display("FAIL beat2_reset_rsp got seen_valid=%0d rdy=%b required 0 0", seen, req_ready[2]);
      end
      arst_n[2] = 1'b1;
      #1;
      compares++;
      if (req_ready[2] !== 1'b1) begin
         mismatches++; $display("FAIL beat2_reset_idle got rdy=%b required 1", req_ready[2]);
      end
      xact(2, 0, 2'd0, 0, 32'h7FF, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'h000000D4) begin
         mismatches++; $display("FAIL beat1_kept got %h required 000000D4", r);
      end
      xact(2, 0, 2'd0, 0, 32'h800, 0, r, e, lat, rdy);
      compares++;
      if (r !== 32'h00000055) begin
         mismatches++; $display("FAIL beat2_dropped got %h required 00000055", r);
      end
   endtask

   initial begin
      arst_n      = 3'b000;
      req_valid   = '0;
      req_we      = '0;
      req_signext = '0;
      req_size    = '0;
      req_addr    = '0;
      req_wdata   = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_basic();
      test_misalign();
      test_nosplit();
      test_back_to_back();
      test_random();
      test_reset_beat2();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

endmodule
